// File: rtl/fetch_unit.sv
// SIC-4 instruction-fetch stage: PC, imem req/ack handshake, instruction register and field split.
// Optional FETCH_PERF_EN adds a saturating consumed-instruction counter on fetch_count.
module fetch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_req,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   dec_ready,
    output logic                   instr_valid,
    output logic [1:0]             op,
    output logic [1:0]             rd,
    output logic [1:0]             rs,
    output logic [1:0]             funct,
    output logic [3:0]             imm,
    output logic [PC_WIDTH-1:0]    instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]            fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_take;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [PC_WIDTH-1:0]    r_instr_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A redirect overrides every state and suppresses capture of a same-cycle ack.
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            IDLE:    w_next = REQ;
            REQ: begin
                if (imem_ack) begin
                    w_next = VALID;
                    w_take = 1'b1;
                end
            end
            VALID: begin
                if (dec_ready) begin
                    w_next = REQ;
                end
            end
            default: w_next = IDLE;
        endcase
        if (redirect_valid) begin
            w_next = REQ;
            w_take = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_instr_pc <= '0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_take) begin
            r_ir       <= imem_rdata;
            r_instr_pc <= r_pc;
            r_pc       <= r_pc + PC_WIDTH'(1);
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = (r_state == REQ);
    assign instr_valid = (r_state == VALID);
    assign op          = r_ir[7:6];
    assign rd          = r_ir[5:4];
    assign rs          = r_ir[3:2];
    assign funct       = r_ir[1:0];
    assign imm         = r_ir[3:0];
    assign instr_pc    = r_instr_pc;

`ifdef FETCH_PERF_EN
    logic        w_consume;
    logic [15:0] r_fetch_count;

    assign w_consume = (r_state == VALID) && dec_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_consume && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule
